// File: rtl/alu_sequencer.sv
// alu_sequencer: programmable initiator for the accumulator ALU.
// A small program RAM is loaded while idle. On start the block fetches and
// issues ALU ops, flag-conditional branches, jumps and halt, one instruction
// every two cycles (FETCH then ISSUE).
module alu_sequencer #(
  parameter int WIDTH          = 8,
  parameter int AW             = 4,
  parameter int MAX_STEPS      = 64,
  parameter int CLEAR_ON_START = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [WIDTH+4:0]   prog_data,
  input  logic               start,
  input  logic [3:0]         alu_flags,
  output logic [2:0]         alu_control,
  output logic [WIDTH-1:0]   alu_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [AW-1:0]      pc
);

  localparam int IW    = WIDTH + 5;
  localparam int DEPTH = 1 << AW;
  localparam int SW    = $clog2(MAX_STEPS + 1);

  // ALU op codes shared with the accumulator ALU
  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;

  // Instruction classes
  localparam logic [1:0] CL_ALU    = 2'b00;
  localparam logic [1:0] CL_BRANCH = 2'b01;
  localparam logic [1:0] CL_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [SW-1:0]     steps_q, steps_d;
  logic [2:0]        ctl_q, ctl_d;
  logic [WIDTH-1:0]  in_q, in_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [IW-1:0]     ir_q;
  logic [IW-1:0]     mem [DEPTH];

  // Instruction fields decoded from the instruction register
  logic [1:0]        ir_cls;
  logic [2:0]        ir_fld;
  logic [WIDTH-1:0]  ir_imm;
  logic [AW-1:0]     ir_tgt;

  assign ir_cls = ir_q[IW-1 -: 2];
  assign ir_fld = ir_q[WIDTH+2:WIDTH];
  assign ir_imm = ir_q[WIDTH-1:0];
  assign ir_tgt = ir_imm[AW-1:0];

  // Program RAM write port; loads are only accepted while idle
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Instruction fetch; the RAM and ir are data and are not reset
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) begin
      ir_q <= mem[pc_q];
    end
  end

  // Control state and registered ALU drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      steps_q <= '0;
      ctl_q   <= OP_HOLD;
      in_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      steps_q <= steps_d;
      ctl_q   <= ctl_d;
      in_q    <= in_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the ALU sees HOLD/0 unless an op is being issued
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    steps_d = steps_q;
    ctl_d   = OP_HOLD;
    in_d    = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          steps_d = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
          if (CLEAR_ON_START != 0) begin
            ctl_d = OP_CLEAR;
          end
        end
      end
      S_FETCH: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Watchdog wins over the fetched instruction, which is dropped
        if (steps_q == SW'(MAX_STEPS)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          steps_d = steps_q + 1'b1;
          state_d = S_FETCH;
          case (ir_cls)
            CL_ALU: begin
              ctl_d = ir_fld;
              in_d  = ir_imm;
              pc_d  = pc_q + 1'b1;
            end
            CL_BRANCH: begin
              // Flags are live from the ALU and reflect the previous op
              pc_d = (alu_flags[ir_fld[1:0]] == ir_fld[2]) ? ir_tgt : pc_q + 1'b1;
            end
            CL_JUMP: begin
              pc_d = ir_tgt;
            end
            default: begin
              // HALT: pc stays on the HALT address
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign alu_control = ctl_q;
  assign alu_in      = in_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign pc          = pc_q;

endmodule
